// File: rtl/chimera_wide_route_ctrl.sv
// chimera_wide_route_ctrl
// Address-region router for the cluster's wide AXI master port. It drives the
// select lines of the adjacent demux and gates AW/AR so that a change of the
// global bypass mode is applied only once the bus has drained.
//
// state | meaning
// ------+----------------------------------------------------------------
// RUN   | traffic flows, selects decoded from mode_q and address
// DRAIN | new AW/AR blocked, waiting for outstanding counters to reach 0
module chimera_wide_route_ctrl #(
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned NumMstPorts    = 2,
  parameter int unsigned NumRegions     = 2,
  parameter int unsigned MaxOutstanding = 16,
  // derived widths; leave at their defaults
  parameter int unsigned SelWidth       = (NumMstPorts > 1) ? $clog2(NumMstPorts) : 1,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1),
  parameter logic [NumRegions-1:0][AddrWidth-1:0] RegionStart = '0,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] RegionEnd   = '0,
  parameter logic [NumRegions-1:0][SelWidth-1:0]  RegionPort  = {NumRegions{SelWidth'(1)}}
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 bypass_mode_i,
  // AW upstream / downstream
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [AddrWidth-1:0] aw_addr_i,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [SelWidth-1:0]  aw_select_o,
  // AR upstream / downstream
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [AddrWidth-1:0] ar_addr_i,
  output logic                 ar_valid_o,
  input  logic                 ar_ready_i,
  output logic [SelWidth-1:0]  ar_select_o,
  // observed responses
  input  logic                 b_valid_i,
  input  logic                 b_ready_i,
  input  logic                 r_valid_i,
  input  logic                 r_ready_i,
  input  logic                 r_last_i,
  // status
  output logic                 bypass_active_o,
  output logic                 draining_o,
  output logic [CntWidth-1:0]  wr_outstanding_o,
  output logic [CntWidth-1:0]  rd_outstanding_o,
  output logic                 err_underflow_o
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  state_e              state_q;
  logic                mode_q;
  logic [CntWidth-1:0] wr_cnt_q;
  logic [CntWidth-1:0] rd_cnt_q;
  logic                err_q;
  logic                aw_pend_q;
  logic                ar_pend_q;

  logic open_aw, open_ar;
  logic aw_inc, ar_inc, b_dec, r_dec;
  logic aw_stall, ar_stall;

  // Lowest-index matching region wins; no match falls back to port 0.
  function automatic logic [SelWidth-1:0] decode(input logic [AddrWidth-1:0] addr);
    logic [SelWidth-1:0] sel;
    logic                hit;
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < int'(NumRegions); i++) begin
      if (!hit && (addr >= RegionStart[i]) && (addr < RegionEnd[i])) begin
        sel = RegionPort[i];
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  // Select decode; bypass forces everything onto the narrow port.
  always_comb begin
    aw_select_o = '0;
    ar_select_o = '0;
    if (!mode_q) begin
      aw_select_o = decode(aw_addr_i);
      ar_select_o = decode(ar_addr_i);
    end
  end

  // Channel gating. A valid that was already presented stays open so it is
  // never withdrawn before acceptance.
  always_comb begin
    open_aw = !rst_i && (aw_pend_q || ((state_q == RUN) && (wr_cnt_q < CntMax)));
    open_ar = !rst_i && (ar_pend_q || ((state_q == RUN) && (rd_cnt_q < CntMax)));
  end

  assign aw_valid_o = aw_valid_i & open_aw;
  assign aw_ready_o = aw_ready_i & open_aw;
  assign ar_valid_o = ar_valid_i & open_ar;
  assign ar_ready_o = ar_ready_i & open_ar;

  assign aw_inc   = aw_valid_o & aw_ready_i;
  assign ar_inc   = ar_valid_o & ar_ready_i;
  assign b_dec    = b_valid_i & b_ready_i;
  assign r_dec    = r_valid_i & r_ready_i & r_last_i;
  assign aw_stall = aw_valid_o & ~aw_ready_i;
  assign ar_stall = ar_valid_o & ~ar_ready_i;

  // Outstanding counters and sticky underflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (aw_inc && !b_dec) begin
        wr_cnt_q <= wr_cnt_q + CntWidth'(1);
      end else if (b_dec && !aw_inc && (wr_cnt_q != '0)) begin
        wr_cnt_q <= wr_cnt_q - CntWidth'(1);
      end
      if (ar_inc && !r_dec) begin
        rd_cnt_q <= rd_cnt_q + CntWidth'(1);
      end else if (r_dec && !ar_inc && (rd_cnt_q != '0)) begin
        rd_cnt_q <= rd_cnt_q - CntWidth'(1);
      end
      if ((b_dec && (wr_cnt_q == '0)) || (r_dec && (rd_cnt_q == '0))) begin
        err_q <= 1'b1;
      end
    end
  end

  // Mode-switch FSM; mode_q only changes with the bus empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      mode_q    <= 1'b0;
      aw_pend_q <= 1'b0;
      ar_pend_q <= 1'b0;
    end else begin
      aw_pend_q <= aw_stall;
      ar_pend_q <= ar_stall;
      case (state_q)
        RUN: begin
          if ((bypass_mode_i != mode_q) && !aw_stall && !ar_stall) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (bypass_mode_i == mode_q) begin
            state_q <= RUN;
          end else if ((wr_cnt_q == '0) && (rd_cnt_q == '0)) begin
            state_q <= RUN;
            mode_q  <= bypass_mode_i;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bypass_active_o  = mode_q;
  assign draining_o       = (state_q == DRAIN);
  assign wr_outstanding_o = wr_cnt_q;
  assign rd_outstanding_o = rd_cnt_q;
  assign err_underflow_o  = err_q;

endmodule

// File: tb/tb_chimera_wide_route_ctrl.sv
// Bench for chimera_wide_route_ctrl: three demux ports, two overlapping
// regions, four outstanding transactions per direction.
module tb_chimera_wide_route_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        bypass_mode_i;
  logic        aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
  logic [47:0] aw_addr_i;
  logic [1:0]  aw_select_o;
  logic        ar_valid_i, ar_ready_o, ar_valid_o, ar_ready_i;
  logic [47:0] ar_addr_i;
  logic [1:0]  ar_select_o;
  logic        b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
  logic        bypass_active_o, draining_o, err_underflow_o;
  logic [2:0]  wr_outstanding_o, rd_outstanding_o;

  always #5 clk = ~clk;

  chimera_wide_route_ctrl #(
    .AddrWidth      (48),
    .NumMstPorts    (3),
    .NumRegions     (2),
    .MaxOutstanding (4),
    .RegionStart    ({48'h1800, 48'h1000}),
    .RegionEnd      ({48'h3000, 48'h2000}),
    .RegionPort     ({2'd2, 2'd1})
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .bypass_mode_i    (bypass_mode_i),
    .aw_valid_i       (aw_valid_i),
    .aw_ready_o       (aw_ready_o),
    .aw_addr_i        (aw_addr_i),
    .aw_valid_o       (aw_valid_o),
    .aw_ready_i       (aw_ready_i),
    .aw_select_o      (aw_select_o),
    .ar_valid_i       (ar_valid_i),
    .ar_ready_o       (ar_ready_o),
    .ar_addr_i        (ar_addr_i),
    .ar_valid_o       (ar_valid_o),
    .ar_ready_i       (ar_ready_i),
    .ar_select_o      (ar_select_o),
    .b_valid_i        (b_valid_i),
    .b_ready_i        (b_ready_i),
    .r_valid_i        (r_valid_i),
    .r_ready_i        (r_ready_i),
    .r_last_i         (r_last_i),
    .bypass_active_o  (bypass_active_o),
    .draining_o       (draining_o),
    .wr_outstanding_o (wr_outstanding_o),
    .rd_outstanding_o (rd_outstanding_o),
    .err_underflow_o  (err_underflow_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] aw_exp[$];
  logic [1:0] ar_exp[$];

  typedef struct {
    logic [47:0] addr;
    logic [1:0]  sel;
  } vec_t;
  vec_t vecs[10];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got timeout/unexpected expected handshake", name);
  endfunction

  // Scoreboard: every accepted AW/AR must match the next expected select.
  always @(negedge clk) begin
    if (!rst_i && aw_valid_o && aw_ready_i) begin
      if (aw_exp.size() == 0) fail_now("aw_unexpected_hs");
      else check("aw_sel_sb", 64'(aw_select_o), 64'(aw_exp.pop_front()));
    end
    if (!rst_i && ar_valid_o && ar_ready_i) begin
      if (ar_exp.size() == 0) fail_now("ar_unexpected_hs");
      else check("ar_sel_sb", 64'(ar_select_o), 64'(ar_exp.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [47:0] a, input logic [1:0] s);
    int n;
    n = 0;
    aw_addr_i  = a;
    aw_valid_i = 1'b1;
    aw_exp.push_back(s);
    #1;
    while (!(aw_valid_o && aw_ready_i) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) fail_now("send_aw_timeout");
    step();
    aw_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{48'h1900, 2'd1};
    vecs[1] = '{48'h2800, 2'd2};
    vecs[2] = '{48'h3000, 2'd0};
    vecs[3] = '{48'h0FFF, 2'd0};
    vecs[4] = '{48'h1000, 2'd1};
    vecs[5] = '{48'h1FFF, 2'd1};
    vecs[6] = '{48'h2000, 2'd2};
    vecs[7] = '{48'h2FFF, 2'd2};
    vecs[8] = '{48'h1800, 2'd1};
    vecs[9] = '{48'hFFFF_0000_1900, 2'd0};

    rst_i = 1'b1; bypass_mode_i = 1'b0;
    aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_addr_i = '0;
    ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_addr_i = '0;
    b_valid_i = 1'b0; b_ready_i = 1'b1; r_valid_i = 1'b0; r_ready_i = 1'b1; r_last_i = 1'b0;
    step(); step();
    check("rst_aw_valid", 64'(aw_valid_o), 0);
    check("rst_aw_ready", 64'(aw_ready_o), 0);
    check("rst_ar_valid", 64'(ar_valid_o), 0);
    check("rst_ar_ready", 64'(ar_ready_o), 0);
    aw_valid_i = 1'b0; ar_valid_i = 1'b0; rst_i = 1'b0;
    #1;
    check("rst_bypass", 64'(bypass_active_o), 0);
    check("rst_drain", 64'(draining_o), 0);
    check("rst_wr", 64'(wr_outstanding_o), 0);
    check("rst_rd", 64'(rd_outstanding_o), 0);
    check("rst_err", 64'(err_underflow_o), 0);

    // Decode table
    for (int i = 0; i < 10; i++) begin
      aw_addr_i = vecs[i].addr;
      ar_addr_i = vecs[i].addr;
      #1;
      check("dec_aw", 64'(aw_select_o), 64'(vecs[i].sel));
      check("dec_ar", 64'(ar_select_o), 64'(vecs[i].sel));
    end

    // Bypass under load
    repeat (3) send_aw(48'h1900, 2'd1);
    check("load_wr3", 64'(wr_outstanding_o), 3);
    bypass_mode_i = 1'b1;
    step();
    check("load_drain", 64'(draining_o), 1);
    check("load_mode_old", 64'(bypass_active_o), 0);
    aw_addr_i = 48'h1900; aw_valid_i = 1'b1; aw_exp.push_back(2'd0);
    b_valid_i = 1'b1;
    #1;
    check("load_aw_blocked", 64'(aw_valid_o), 0);
    repeat (3) begin
      step();
      check("load_aw_blocked_b", 64'(aw_valid_o), 0);
    end
    b_valid_i = 1'b0;
    n = 0;
    while (!(aw_valid_o && aw_ready_i) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) fail_now("load_aw_timeout");
    check("load_mode_new", 64'(bypass_active_o), 1);
    check("load_aw_sel", 64'(aw_select_o), 0);
    step();
    aw_valid_i = 1'b0;
    b_valid_i = 1'b1;
    step();
    b_valid_i = 1'b0;
    check("load_wr0", 64'(wr_outstanding_o), 0);

    // Idle switch back to mode 0: DRAIN one cycle, then RUN with new mode
    bypass_mode_i = 1'b0;
    step();
    check("idle_drain", 64'(draining_o), 1);
    check("idle_mode_hold", 64'(bypass_active_o), 1);
    step();
    check("idle_run", 64'(draining_o), 0);
    check("idle_mode_new", 64'(bypass_active_o), 0);

    // Outstanding limit
    ar_addr_i = 48'h2800;
    repeat (5) ar_exp.push_back(2'd2);
    ar_valid_i = 1'b1;
    repeat (4) step();
    check("lim_rd4", 64'(rd_outstanding_o), 4);
    check("lim_ar_valid", 64'(ar_valid_o), 0);
    check("lim_ar_ready", 64'(ar_ready_o), 0);
    r_valid_i = 1'b1; r_last_i = 1'b0;
    step();
    check("lim_nolast_rd4", 64'(rd_outstanding_o), 4);
    check("lim_ar_still", 64'(ar_valid_o), 0);
    r_last_i = 1'b1;
    step();
    r_valid_i = 1'b0; r_last_i = 1'b0;
    check("lim_rd3", 64'(rd_outstanding_o), 3);
    check("lim_ar_release", 64'(ar_valid_o), 1);
    step();
    ar_valid_i = 1'b0;
    check("lim_rd4b", 64'(rd_outstanding_o), 4);
    r_valid_i = 1'b1; r_last_i = 1'b1;
    repeat (4) step();
    r_valid_i = 1'b0; r_last_i = 1'b0;
    check("lim_rd0", 64'(rd_outstanding_o), 0);
    check("lim_no_err", 64'(err_underflow_o), 0);

    // Valid stability
    aw_ready_i = 1'b0; aw_addr_i = 48'h1900; aw_valid_i = 1'b1; aw_exp.push_back(2'd1);
    bypass_mode_i = 1'b1;
    #1;
    check("stab_valid0", 64'(aw_valid_o), 1);
    repeat (2) begin
      step();
      check("stab_run", 64'(draining_o), 0);
      check("stab_valid", 64'(aw_valid_o), 1);
      check("stab_sel", 64'(aw_select_o), 1);
    end
    aw_ready_i = 1'b1;
    #1;
    check("stab_run_hs", 64'(draining_o), 0);
    step();
    aw_valid_i = 1'b0;
    check("stab_drain", 64'(draining_o), 1);
    b_valid_i = 1'b1;
    step();
    b_valid_i = 1'b0;
    step();
    check("stab_mode1", 64'(bypass_active_o), 1);
    bypass_mode_i = 1'b0;
    step(); step();
    check("stab_mode0", 64'(bypass_active_o), 0);

    // Toggle withdrawn
    repeat (2) send_aw(48'h1900, 2'd1);
    bypass_mode_i = 1'b1;
    step();
    check("wd_drain", 64'(draining_o), 1);
    bypass_mode_i = 1'b0;
    step();
    check("wd_run", 64'(draining_o), 0);
    check("wd_mode", 64'(bypass_active_o), 0);
    check("wd_wr2", 64'(wr_outstanding_o), 2);
    b_valid_i = 1'b1;
    step(); step();
    b_valid_i = 1'b0;
    check("wd_wr0", 64'(wr_outstanding_o), 0);

    // Underflow
    b_valid_i = 1'b1;
    step();
    b_valid_i = 1'b0;
    check("uf_err", 64'(err_underflow_o), 1);
    check("uf_wr0", 64'(wr_outstanding_o), 0);
    step();
    check("uf_sticky", 64'(err_underflow_o), 1);

    // Reset with mode 1 and a read outstanding
    bypass_mode_i = 1'b1;
    step(); step();
    check("rs_mode1", 64'(bypass_active_o), 1);
    ar_addr_i = 48'h2800; ar_valid_i = 1'b1; ar_exp.push_back(2'd0);
    step();
    ar_valid_i = 1'b0;
    check("rs_rd1", 64'(rd_outstanding_o), 1);
    rst_i = 1'b1; bypass_mode_i = 1'b0; aw_valid_i = 1'b1;
    #1;
    check("rs_aw_gated", 64'(aw_valid_o), 0);
    step();
    rst_i = 1'b0; aw_valid_i = 1'b0;
    check("rs_err", 64'(err_underflow_o), 0);
    check("rs_wr", 64'(wr_outstanding_o), 0);
    check("rs_rd", 64'(rd_outstanding_o), 0);
    check("rs_mode", 64'(bypass_active_o), 0);
    check("rs_drain", 64'(draining_o), 0);

    step();
    check("aw_sb_empty", 64'(aw_exp.size()), 0);
    check("ar_sb_empty", 64'(ar_exp.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
